// File: rtl/dram_resp.sv
// dram_resp
//   Responder end of the hxd32 data-memory interface. Holds a byte-writable
//   word RAM with a one-cycle registered read path. Any access outside the
//   mapped ranges sets a sticky fault flag. An optional MMIO block adds a
//   64-bit cycle counter and a scratch register.
//
//   Build option: define DRAM_RESP_MMIO_EN to map the MMIO block at
//   MMIO_BASE..MMIO_BASE+0xF:
//     +0x0 counter low word; a read also snapshots the counter high word
//     +0x4 high word captured at the last +0x0 read
//     +0x8 byte-writable scratch register
//     +0xC reserved
//   Without the macro, that window decodes as out-of-range.
//
// Ports
//   clk_i              clock
//   rst_n_i            async active-low system reset
//   dram_rd_addr_i     read byte address (bits [1:0] ignored)
//   dram_rd_data_o     read data, one cycle after the address
//   dram_wr_addr_i     write byte address (bits [1:0] ignored)
//   dram_wr_data_i     write data, lane k = bits [8k+7:8k]
//   dram_wr_byte_en_i  per-lane write enable, 4'b0000 = idle
//   dram_fault_o       sticky out-of-range access flag
module dram_resp #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'h2000_0000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [XLEN-1:0] dram_rd_addr_i,
  output logic [XLEN-1:0] dram_rd_data_o,
  input  logic [XLEN-1:0] dram_wr_addr_i,
  input  logic [XLEN-1:0] dram_wr_data_i,
  input  logic [3:0]      dram_wr_byte_en_i,
  output logic            dram_fault_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(DEPTH * 4);

  // Replace the enabled byte lanes of old_word with the lanes of new_word.
  function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old_word,
                                                  input logic [XLEN-1:0] new_word,
                                                  input logic [3:0]      en);
    merge_lanes = old_word;
    for (int k = 0; k < 4; k++) begin
      if (en[k]) merge_lanes[8*k +: 8] = new_word[8*k +: 8];
    end
  endfunction

  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] rd_off, wr_off;
  logic            rd_hit, wr_hit, wr_en, wr_ram;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic [XLEN-1:0] ram_word;
  logic            rd_mmio, wr_mmio;
  logic [XLEN-1:0] mmio_word;

  // The offset is unsigned, so an address below BASE_ADDR wraps to a large
  // value. A single compare therefore checks both ends of the window.
  assign rd_off = dram_rd_addr_i - BASE_ADDR;
  assign wr_off = dram_wr_addr_i - BASE_ADDR;
  assign rd_hit = rd_off < RAM_BYTES;
  assign wr_hit = wr_off < RAM_BYTES;
  assign rd_idx = rd_off[AW+1:2];
  assign wr_idx = wr_off[AW+1:2];
  assign wr_en  = |dram_wr_byte_en_i;
  assign wr_ram = wr_en && wr_hit;

  // A write is held off while reset is asserted. This drops any access
  // that is in flight when reset arrives.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && wr_ram) begin
      for (int k = 0; k < 4; k++) begin
        if (dram_wr_byte_en_i[k]) mem[wr_idx][8*k +: 8] <= dram_wr_data_i[8*k +: 8];
      end
    end
  end

  // Write-first: a read of the word being written on the same edge
  // returns the merged word.
  always_comb begin
    ram_word = mem[rd_idx];
    if (wr_ram && rd_hit && (wr_idx == rd_idx)) begin
      ram_word = merge_lanes(ram_word, dram_wr_data_i, dram_wr_byte_en_i);
    end
  end

`ifdef DRAM_RESP_MMIO_EN
  logic [63:0]     cnt;
  logic [XLEN-1:0] cnt_shadow, scratch;
  logic            scratch_wr;

  assign rd_mmio    = dram_rd_addr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign wr_mmio    = dram_wr_addr_i[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign scratch_wr = wr_en && wr_mmio && (dram_wr_addr_i[3:2] == 2'd2);

  always_comb begin
    case (dram_rd_addr_i[3:2])
      2'd0:    mmio_word = cnt[XLEN-1:0];
      2'd1:    mmio_word = cnt_shadow;
      2'd2:    mmio_word = scratch_wr ? merge_lanes(scratch, dram_wr_data_i, dram_wr_byte_en_i)
                                      : scratch;
      default: mmio_word = '0;
    endcase
  end

  // A low-word read captures the high word on the same edge. A later
  // high-word read then pairs consistently with the low word already seen.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt        <= '0;
      cnt_shadow <= '0;
      scratch    <= '0;
    end else begin
      cnt <= cnt + 64'd1;
      if (rd_mmio && (dram_rd_addr_i[3:2] == 2'd0)) cnt_shadow <= cnt[63:32];
      if (scratch_wr) scratch <= merge_lanes(scratch, dram_wr_data_i, dram_wr_byte_en_i);
    end
  end
`else
  assign rd_mmio   = 1'b0;
  assign wr_mmio   = 1'b0;
  assign mmio_word = '0;
`endif

  // An unmapped read returns zero. An unmapped read, or an unmapped write
  // with lanes enabled, latches the fault flag until reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dram_rd_data_o <= '0;
      dram_fault_o   <= 1'b0;
    end else begin
      if (rd_hit)       dram_rd_data_o <= ram_word;
      else if (rd_mmio) dram_rd_data_o <= mmio_word;
      else              dram_rd_data_o <= '0;
      if ((!rd_hit && !rd_mmio) || (wr_en && !wr_hit && !wr_mmio)) dram_fault_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_resp.sv
// tb_dram_resp
//   Directed bench for dram_resp.
//   A byte-level memory model sits beside the DUT. That model tracks which
//   bytes hold known data. A per-cycle compare process checks read data on
//   known bytes and checks the fault flag. Literal expectations in the
//   directed sequence pin the model itself.
module tb_dram_resp;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] MMIO  = 32'h2000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd_addr = BASE;
  logic [31:0] wr_addr = BASE;
  logic [31:0] wr_data = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] rd_data;
  logic        fault;

  dram_resp dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .dram_rd_addr_i    (rd_addr),
    .dram_rd_data_o    (rd_data),
    .dram_wr_addr_i    (wr_addr),
    .dram_wr_data_i    (wr_data),
    .dram_wr_byte_en_i (byte_en),
    .dram_fault_o      (fault)
  );

  always #5 clk = ~clk;

  // Model state: memory bytes, a known-lane mask per word, and MMIO registers.
  bit [31:0] m_data  [DEPTH];
  bit [3:0]  m_known [DEPTH];
  bit [31:0] exp_rd, exp_mask;
  bit        exp_fault;
  bit [63:0] m_cnt;
  bit [31:0] m_shadow, m_scratch;
  bit        ovr_en = 1'b0;
  bit [63:0] ovr_val = '0;

  function automatic bit in_ram(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(DEPTH * 4));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
`ifdef DRAM_RESP_MMIO_EN
    return (a >= MMIO) && (a < MMIO + 32'd16);
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic bit [31:0] lanes(input logic [3:0] b);
    bit [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (b[k]) m[8*k +: 8] = 8'hFF;
    return m;
  endfunction

  // What the next registered read and fault values must be.
  bit [31:0] nx_rd, nx_mask, lm, cur_cnt;
  bit [63:0] cnt_now;
  bit        nx_bad;
  always_comb begin
    cnt_now = ovr_en ? ovr_val : m_cnt;
    lm      = lanes(byte_en);
    nx_rd   = '0;
    nx_mask = '1;
    nx_bad  = 1'b0;
    cur_cnt = cnt_now[31:0];
    if (in_ram(rd_addr)) begin
      nx_rd   = m_data[word_of(rd_addr)];
      nx_mask = lanes(m_known[word_of(rd_addr)]);
      if (byte_en != 0 && in_ram(wr_addr) && word_of(wr_addr) == word_of(rd_addr)) begin
        nx_rd   = (nx_rd & ~lm) | (wr_data & lm);
        nx_mask = nx_mask | lm;
      end
    end else if (in_mmio(rd_addr)) begin
      case ((rd_addr - MMIO) >> 2)
        32'd0: nx_rd = cur_cnt;
        32'd1: nx_rd = m_shadow;
        32'd2: begin
          nx_rd = m_scratch;
          if (byte_en != 0 && ((wr_addr - MMIO) >> 2) == 32'd2 && in_mmio(wr_addr))
            nx_rd = (nx_rd & ~lm) | (wr_data & lm);
        end
        default: nx_rd = '0;
      endcase
    end else begin
      nx_bad = 1'b1;
    end
    if (byte_en != 0 && !in_ram(wr_addr) && !in_mmio(wr_addr)) nx_bad = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rd    <= '0;
      exp_mask  <= '1;
      exp_fault <= 1'b0;
      m_cnt     <= '0;
      m_shadow  <= '0;
      m_scratch <= '0;
    end else begin
      exp_rd   <= nx_rd;
      exp_mask <= nx_mask;
      if (nx_bad) exp_fault <= 1'b1;
      if (byte_en != 0 && in_ram(wr_addr)) begin
        m_data[word_of(wr_addr)]  <= (m_data[word_of(wr_addr)] & ~lm) | (wr_data & lm);
        m_known[word_of(wr_addr)] <= m_known[word_of(wr_addr)] | byte_en;
      end
      if (byte_en != 0 && in_mmio(wr_addr) && ((wr_addr - MMIO) >> 2) == 32'd2)
        m_scratch <= (m_scratch & ~lm) | (wr_data & lm);
      if (in_mmio(rd_addr) && ((rd_addr - MMIO) >> 2) == 32'd0) m_shadow <= cnt_now[63:32];
      m_cnt <= cnt_now + 64'd1;
    end
  end

  // Literal expectation posted by the directed sequence.
  string     lit_name = "";
  bit [31:0] lit_rd, lit_mask;
  bit        lit_fault;
  int        lit_seq = 0;

  int checks = 0;
  int errors = 0;

  // Single compare process: model check every cycle, plus any pending literal.
  initial begin : compare
    int seen_seq;
    seen_seq = 0;
    forever begin
      @(negedge clk);
      checks++;
      if ((rd_data & exp_mask) !== (exp_rd & exp_mask)) begin
        errors++;
        $display("[TB] FAIL model_rd_data t=%0t got %h want %h (mask %h)", $time, rd_data, exp_rd, exp_mask);
      end
      checks++;
      if (fault !== exp_fault) begin
        errors++;
        $display("[TB] FAIL model_fault t=%0t got %b want %b", $time, fault, exp_fault);
      end
      if (lit_seq != seen_seq) begin
        seen_seq = lit_seq;
        checks++;
        if ((rd_data & lit_mask) !== (lit_rd & lit_mask)) begin
          errors++;
          $display("[TB] FAIL %s rd_data got %h want %h", lit_name, rd_data, lit_rd);
        end
        checks++;
        if (fault !== lit_fault) begin
          errors++;
          $display("[TB] FAIL %s fault got %b want %b", lit_name, fault, lit_fault);
        end
      end
    end
  end

  task automatic postLiteral(input string name, input logic [31:0] erd,
                             input logic [31:0] emask, input bit efault);
    lit_name  = name;
    lit_rd    = erd;
    lit_mask  = emask;
    lit_fault = efault;
    lit_seq++;
  endtask

  // Drive one cycle of inputs at the falling edge.
  task automatic applyStimulus(input logic [31:0] ra, input logic [31:0] wa,
                               input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    rd_addr = ra;
    wr_addr = wa;
    wr_data = wd;
    byte_en = be;
  endtask

  // Expectation for the edge that samples the inputs just applied.
  task automatic checkOutput(input string name, input logic [31:0] erd,
                             input logic [31:0] emask, input bit efault);
    @(posedge clk);
    #1;
    postLiteral(name, erd, emask, efault);
  endtask

  task automatic idle();
    applyStimulus(BASE, BASE, 32'h0, 4'b0000);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n   = 1'b0;
    rd_addr = BASE;
    wr_addr = BASE;
    byte_en = 4'b0000;
    #1;
    postLiteral("reset", 32'h0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] ra, wa, wd;
    logic [3:0]  be;
    logic [31:0] erd, emask;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{BASE,          BASE + 32'hFFC, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'h0};
    vecs[1] = '{BASE + 32'hFFC, BASE,          32'h0102_0304, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_FFFF};
    vecs[2] = '{BASE,          BASE + 32'h8,   32'h1122_3344, 4'b1111, 32'h0102_0304, 32'hFFFF_FFFF};
    vecs[3] = '{BASE + 32'h8,  BASE + 32'h8,   32'hAABB_CCDD, 4'b1010, 32'hAA22_CC44, 32'hFFFF_FFFF};
    vecs[4] = '{BASE + 32'h8,  BASE + 32'hC,   32'h5A5A_5A5A, 4'b0000, 32'hAA22_CC44, 32'hFFFF_FFFF};
    vecs[5] = '{BASE + 32'h4,  BASE,           32'h0,         4'b0000, 32'hDEAD_BEAA, 32'hFFFF_FFFF};

    doReset();

    // Full write, then a read one cycle later.
    applyStimulus(BASE, BASE + 32'h4, 32'hDEAD_BEEF, 4'b1111);
    applyStimulus(BASE + 32'h4, BASE, 32'h0, 4'b0000);
    checkOutput("full_write_read", 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0);

    // Same-edge read and single-lane write of one word.
    applyStimulus(BASE + 32'h4, BASE + 32'h4, 32'h0000_00AA, 4'b0001);
    checkOutput("write_first_merge", 32'hDEAD_BEAA, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].ra, vecs[i].wa, vecs[i].wd, vecs[i].be);
      checkOutput($sformatf("vec%0d", i), vecs[i].erd, vecs[i].emask, 1'b0);
    end

    // Write just below the RAM window.
    applyStimulus(BASE, 32'h0FFF_FFFC, 32'h5555_5555, 4'b1111);
    checkOutput("wr_below_base", 32'h0102_0304, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(BASE, BASE, 32'h0, 4'b0000);
    checkOutput("wr_below_no_change", 32'h0102_0304, 32'hFFFF_FFFF, 1'b1);

    // Idle writes to unmapped addresses.
    doReset();
    applyStimulus(BASE, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'b0000);
    checkOutput("idle_wr_no_fault", 32'h0102_0304, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(BASE, 32'h3000_0000, 32'h1234_5678, 4'b0000);
    checkOutput("idle_wr_no_fault2", 32'h0102_0304, 32'hFFFF_FFFF, 1'b0);

    // Read one word past the end; the flag is sticky.
    applyStimulus(BASE + 32'h1000, BASE, 32'h0, 4'b0000);
    checkOutput("rd_past_end", 32'h0, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(BASE + 32'hFFC, BASE, 32'h0, 4'b0000);
    checkOutput("fault_sticky_rd", 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(BASE + 32'h4, BASE + 32'h4, 32'h1357_9BDF, 4'b1111);
    checkOutput("fault_sticky_wr", 32'h1357_9BDF, 32'hFFFF_FFFF, 1'b1);

    // In-range write alongside an out-of-range read.
    doReset();
    applyStimulus(BASE + 32'h1000, BASE + 32'h10, 32'h0BAD_F00D, 4'b1111);
    checkOutput("oor_rd_with_wr", 32'h0, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(BASE + 32'h10, BASE, 32'h0, 4'b0000);
    checkOutput("wr_completed", 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b1);

    doReset();
    applyStimulus(32'h0FFF_FFFC, BASE, 32'h0, 4'b0000);
    checkOutput("rd_below_base", 32'h0, 32'hFFFF_FFFF, 1'b1);

    doReset();
`ifdef DRAM_RESP_MMIO_EN
    // After reset release, each idle call passes one clock edge.
    // 99 idle cycles plus the edge that presents the address give a
    // sampled count of 100.
    for (int i = 0; i < 99; i++) idle();
    applyStimulus(MMIO, BASE, 32'h0, 4'b0000);
    checkOutput("cnt_lo_100", 32'd100, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MMIO + 32'h4, BASE, 32'h0, 4'b0000);
    checkOutput("cnt_hi_0", 32'h0, 32'hFFFF_FFFF, 1'b0);

    @(negedge clk);
    force dut.cnt = 64'h0000_0000_FFFF_FFFF;
    release dut.cnt;
    ovr_val = 64'h0000_0000_FFFF_FFFF;
    ovr_en  = 1'b1;
    rd_addr = MMIO;
    byte_en = 4'b0000;
    checkOutput("cnt_lo_forced", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    ovr_en = 1'b0;
    applyStimulus(MMIO + 32'h4, BASE, 32'h0, 4'b0000);
    checkOutput("cnt_hi_snapshot", 32'h0, 32'hFFFF_FFFF, 1'b0);

    applyStimulus(BASE, MMIO + 32'h8, 32'h1234_5678, 4'b1100);
    checkOutput("scratch_wr", 32'h0102_0304, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MMIO + 32'h8, MMIO, 32'hFFFF_FFFF, 4'b1111);
    checkOutput("scratch_rd", 32'h1234_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(MMIO + 32'hC, MMIO + 32'hC, 32'hFFFF_FFFF, 4'b1111);
    checkOutput("reserved_rd", 32'h0, 32'hFFFF_FFFF, 1'b0);
`else
    applyStimulus(BASE, MMIO + 32'h8, 32'h1234_5678, 4'b1100);
    checkOutput("mmio_wr_unmapped", 32'h0102_0304, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(MMIO + 32'h8, BASE, 32'h0, 4'b0000);
    checkOutput("mmio_rd_unmapped", 32'h0, 32'hFFFF_FFFF, 1'b1);
`endif

    idle();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
